// File: rtl/dsp_mac_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : dsp_mac_stream
//  Description : Signed streaming multiply-accumulate slice. One frame
//                (first..last beats) produces one dot-product result.
//                Three-stage pipeline: S1 operands + pre-adder, S2 product,
//                S3 accumulate/emit. Valid/ready handshake on both sides.
//  Ports       : clk, RSTN (async, active low)
//                in_valid/in_ready, A, B, D, C, OPMODE[3:0], in_first, in_last
//                out_valid/out_ready, P, OVF (per-frame overflow), ERR (sticky)
//  Options     : DSP_MAC_SAT_EN - saturate the accumulator on overflow
//                (default: wrap modulo 2^P_WIDTH)
//  Revision    : 1.0 - initial release
// ============================================================================
module dsp_mac_stream #(
    parameter int A_WIDTH = 18,
    parameter int B_WIDTH = 18,
    parameter int D_WIDTH = 18,
    parameter int C_WIDTH = 48,
    parameter int P_WIDTH = 48
) (
    input  logic                      clk,
    input  logic                      RSTN,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [A_WIDTH-1:0] A,
    input  logic signed [B_WIDTH-1:0] B,
    input  logic signed [D_WIDTH-1:0] D,
    input  logic signed [C_WIDTH-1:0] C,
    input  logic        [3:0]         OPMODE,
    input  logic                      in_first,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [P_WIDTH-1:0] P,
    output logic                      OVF,
    output logic                      ERR
);
    localparam int c_bd_w   = ((B_WIDTH > D_WIDTH) ? B_WIDTH : D_WIDTH) + 1;
    localparam int c_prod_w = A_WIDTH + c_bd_w;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    // ready_en_q keeps in_ready low until the first edge after reset release
    logic                       ready_en_q, ready_en_d;
    // S1: operands and pre-adder result; op keeps {post-sub, seed}
    logic                       s1_valid_q, s1_valid_d;
    logic signed [A_WIDTH-1:0]  s1_a_q, s1_a_d;
    logic signed [c_bd_w-1:0]   s1_bd_q, s1_bd_d;
    logic signed [C_WIDTH-1:0]  s1_c_q, s1_c_d;
    logic        [1:0]          s1_op_q, s1_op_d;
    logic                       s1_first_q, s1_first_d, s1_last_q, s1_last_d;
    // S2: product
    logic                       s2_valid_q, s2_valid_d;
    logic signed [c_prod_w-1:0] s2_prod_q, s2_prod_d;
    logic signed [C_WIDTH-1:0]  s2_c_q, s2_c_d;
    logic        [1:0]          s2_op_q, s2_op_d;
    logic                       s2_first_q, s2_first_d, s2_last_q, s2_last_d;
    // S3: accumulator, frame state and result register
    state_t                     state_q, state_d;
    logic signed [P_WIDTH-1:0]  acc_q, acc_d;
    logic                       ovf_acc_q, ovf_acc_d;
    logic signed [P_WIDTH-1:0]  p_q, p_d;
    logic                       ovf_q, ovf_d;
    logic                       out_valid_q, out_valid_d;
    logic                       err_q, err_d;

    logic                       w_advance;
    logic signed [c_bd_w-1:0]   w_b_ext, w_d_ext, w_pre;
    logic signed [P_WIDTH-1:0]  w_prod_ext, w_x, w_z, w_base, w_sum, w_res;
    logic                       w_ovf, w_emit;

    // The whole pipeline moves only when the result slot is free or being taken.
    assign w_advance = ~out_valid_q | out_ready;
    assign in_ready  = ready_en_q & w_advance;
    assign out_valid = out_valid_q;
    assign P         = p_q;
    assign OVF       = ovf_q;
    assign ERR       = err_q;

    // S1 / S2 next-state: data and valids load together on advance
    always_comb begin
        w_b_ext = c_bd_w'(B);
        w_d_ext = c_bd_w'(D);
        w_pre   = OPMODE[0] ? (w_d_ext - w_b_ext) : (w_d_ext + w_b_ext);

        ready_en_d = 1'b1;
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_bd_d    = s1_bd_q;
        s1_c_d     = s1_c_q;
        s1_op_d    = s1_op_q;
        s1_first_d = s1_first_q;
        s1_last_d  = s1_last_q;
        s2_valid_d = s2_valid_q;
        s2_prod_d  = s2_prod_q;
        s2_c_d     = s2_c_q;
        s2_op_d    = s2_op_q;
        s2_first_d = s2_first_q;
        s2_last_d  = s2_last_q;
        if (w_advance) begin
            s1_valid_d = in_valid & in_ready;
            s1_a_d     = A;
            s1_bd_d    = OPMODE[1] ? w_pre : w_b_ext;
            s1_c_d     = C;
            s1_op_d    = OPMODE[3:2];
            s1_first_d = in_first;
            s1_last_d  = in_last;
            s2_valid_d = s1_valid_q;
            s2_prod_d  = c_prod_w'(s1_a_q) * c_prod_w'(s1_bd_q);
            s2_c_d     = s1_c_q;
            s2_op_d    = s1_op_q;
            s2_first_d = s1_first_q;
            s2_last_d  = s1_last_q;
        end
    end

    // S3 datapath: X = +/-product, base = seed (frame start) or running acc
    always_comb begin
        w_prod_ext = P_WIDTH'(s2_prod_q);
        w_x        = s2_op_q[1] ? -w_prod_ext : w_prod_ext;
        w_z        = s2_op_q[0] ? P_WIDTH'(s2_c_q) : '0;
        w_base     = s2_first_q ? w_z : acc_q;
        w_sum      = w_base + w_x;
        w_ovf      = (w_base[P_WIDTH-1] == w_x[P_WIDTH-1]) &&
                     (w_sum[P_WIDTH-1] != w_base[P_WIDTH-1]);
`ifdef DSP_MAC_SAT_EN
        // Clamp toward the sign of the operands that overflowed.
        if (w_ovf) begin
            w_res = w_base[P_WIDTH-1] ? {1'b1, {(P_WIDTH-1){1'b0}}}
                                      : {1'b0, {(P_WIDTH-1){1'b1}}};
        end else begin
            w_res = w_sum;
        end
`else
        w_res = w_sum;
`endif
    end

    // S3 frame FSM and result register
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        ovf_acc_d   = ovf_acc_q;
        p_d         = p_q;
        ovf_d       = ovf_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        w_emit      = 1'b0;
        if (w_advance && s2_valid_q) begin
            if (s2_first_q) begin
                // A first beat inside an open frame abandons that frame.
                if (state_q == ST_ACCUM) begin
                    err_d = 1'b1;
                end
                acc_d     = w_res;
                ovf_acc_d = w_ovf;
                w_emit    = s2_last_q;
                state_d   = s2_last_q ? ST_IDLE : ST_ACCUM;
            end else if (state_q == ST_ACCUM) begin
                acc_d     = w_res;
                ovf_acc_d = ovf_acc_q | w_ovf;
                w_emit    = s2_last_q;
                state_d   = s2_last_q ? ST_IDLE : ST_ACCUM;
            end else begin
                err_d = 1'b1;
            end
        end
        if (w_emit) begin
            out_valid_d = 1'b1;
            p_d         = w_res;
            ovf_d       = w_ovf | (~s2_first_q & ovf_acc_q);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            ready_en_q  <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_bd_q     <= '0;
            s1_c_q      <= '0;
            s1_op_q     <= '0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_prod_q   <= '0;
            s2_c_q      <= '0;
            s2_op_q     <= '0;
            s2_first_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            ovf_acc_q   <= 1'b0;
            p_q         <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            ready_en_q  <= ready_en_d;
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_bd_q     <= s1_bd_d;
            s1_c_q      <= s1_c_d;
            s1_op_q     <= s1_op_d;
            s1_first_q  <= s1_first_d;
            s1_last_q   <= s1_last_d;
            s2_valid_q  <= s2_valid_d;
            s2_prod_q   <= s2_prod_d;
            s2_c_q      <= s2_c_d;
            s2_op_q     <= s2_op_d;
            s2_first_q  <= s2_first_d;
            s2_last_q   <= s2_last_d;
            state_q     <= state_d;
            acc_q       <= acc_d;
            ovf_acc_q   <= ovf_acc_d;
            p_q         <= p_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dsp_mac_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_dsp_mac_stream
//  Description : Scoreboard bench for dsp_mac_stream (8x8 operands, 16-bit
//                accumulator). Stimulus pushes expected frame results; a
//                monitor pops and compares on every output handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dsp_mac_stream;
    localparam int AW = 8;
    localparam int BW = 8;
    localparam int DW = 8;
    localparam int CW = 16;
    localparam int PW = 16;
`ifdef DSP_MAC_SAT_EN
    localparam int EXP_POS_OVF = 32767;
    localparam int EXP_NEG_OVF = -32768;
`else
    localparam int EXP_POS_OVF = -17149;
    localparam int EXP_NEG_OVF = 16768;
`endif

    logic                 clk       = 1'b0;
    logic                 RSTN      = 1'b1;
    logic                 in_valid  = 1'b0;
    logic                 in_first  = 1'b0;
    logic                 in_last   = 1'b0;
    logic                 out_ready = 1'b1;
    logic signed [AW-1:0] A = '0;
    logic signed [BW-1:0] B = '0;
    logic signed [DW-1:0] D = '0;
    logic signed [CW-1:0] C = '0;
    logic        [3:0]    OPMODE = '0;
    logic                 in_ready, out_valid, OVF, ERR;
    logic signed [PW-1:0] P;

    dsp_mac_stream #(
        .A_WIDTH(AW), .B_WIDTH(BW), .D_WIDTH(DW), .C_WIDTH(CW), .P_WIDTH(PW)
    ) dut (
        .clk(clk), .RSTN(RSTN), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .D(D), .C(C), .OPMODE(OPMODE),
        .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .P(P), .OVF(OVF), .ERR(ERR)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic signed [PW-1:0] p;
        logic                 ovf;
        int                   acc_cyc;
        bit                   lat;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;
    int max_wait = 0;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Present one beat and hold it until accepted; optionally push the
    // expected frame result (on the last beat).
    task automatic send(input int a, input int b, input int d, input int c,
                        input logic [3:0] op, input logic first, input logic last,
                        input bit push, input int exp_p, input logic exp_ovf,
                        input bit lat);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        A = AW'(a); B = BW'(b); D = DW'(d); C = CW'(c);
        OPMODE = op; in_first = first; in_last = last; in_valid = 1'b1;
        #1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n > max_wait) max_wait = n;
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: in_ready=%0b, expected 1", in_ready);
            in_valid = 1'b0;
        end else begin
            if (push) begin
                e.p = PW'(exp_p); e.ovf = exp_ovf; e.acc_cyc = cyc; e.lat = lat;
                sb.push_back(e);
            end
            @(posedge clk);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        RSTN = 1'b0;
        @(negedge clk);
        RSTN = 1'b1;
        @(posedge clk);
    endtask

    // Monitor: result compare on handshake, stability under back-pressure.
    initial begin : monitor
        logic signed [PW-1:0] held_p;
        logic                 held_ovf;
        bit                   holding;
        exp_t                 e;
        holding = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!RSTN) begin
                holding = 1'b0;
            end else begin
                if (holding) begin
                    check("hold_P", P, held_p);
                    check("hold_OVF", OVF, held_ovf);
                end
                if (out_valid && !out_ready) begin
                    check("stall_in_ready", in_ready, 0);
                    holding  = 1'b1;
                    held_p   = P;
                    held_ovf = OVF;
                end else begin
                    holding = 1'b0;
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_out: P=%0d, expected no result", P);
                    end else begin
                        e = sb.pop_front();
                        check("P", P, e.p);
                        check("OVF", OVF, e.ovf);
                        if (e.lat) check("latency", cyc - e.acc_cyc, 3);
                    end
                end
            end
        end
    end

    initial begin
        // Reset state
        #2 RSTN = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_P", P, 0);
        check("rst_OVF", OVF, 0);
        check("rst_ERR", ERR, 0);
        check("rst_in_ready", in_ready, 0);
        @(negedge clk);
        RSTN = 1'b1;
        #1;
        check("in_ready_before_edge", in_ready, 0);
        @(posedge clk);
        #1;
        check("in_ready_after_edge", in_ready, 1);

        // Mid-frame reset with two beats in flight
        send(5, 5, 0, 0, 4'b0000, 1, 0, 0, 0, 0, 0);
        send(6, 6, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        RSTN = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_P", P, 0);
        check("midrst_ERR", ERR, 0);
        @(negedge clk);
        RSTN = 1'b1;
        idle(2);

        // Single-beat frame: 100 + 3*(10-4)
        send(3, 4, 10, 100, 4'b0111, 1, 1, 1, 118, 0, 1);
        idle(1);
        drain();

        // Back-to-back frames, no bubbles
        max_wait = 0;
        send(1, 5, 0, 0, 4'b0000, 1, 0, 0, 0, 0, 0);
        send(2, 6, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
        send(3, 7, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
        send(4, 8, 0, 0, 4'b0000, 0, 1, 1, 70, 0, 1);
        send(2, 3, -5, 0, 4'b0011, 1, 0, 0, 0, 0, 0);      // 2*(-8)
        send(-4, 1, 6, 0, 4'b0011, 0, 1, 1, -36, 0, 1);    // + (-4)*5
        send(-3, 7, 0, 0, 4'b1000, 1, 0, 0, 0, 0, 0);      // -(-21)
        send(10, -2, 0, 0, 4'b1000, 0, 1, 1, 41, 0, 1);    // -(-20)
        send(5, 3, 4, -5, 4'b0110, 1, 1, 1, 30, 0, 1);     // -5 + 5*7
        check("no_bubble_waits", max_wait, 0);
        idle(1);
        drain();

        // Back-pressure: consumer stalls 5 cycles while beats keep coming
        fork
            begin
                send(1, 1, 0, 0, 4'b0000, 1, 0, 0, 0, 0, 0);
                send(1, 2, 0, 0, 4'b0000, 0, 1, 1, 3, 0, 0);
                send(2, 3, 0, 0, 4'b0000, 1, 0, 0, 0, 0, 0);
                send(2, 4, 0, 0, 4'b0000, 0, 1, 1, 14, 0, 0);
                send(-1, 5, 0, 0, 4'b0000, 1, 0, 0, 0, 0, 0);
                send(-1, 5, 0, 0, 4'b0000, 0, 1, 1, -10, 0, 0);
                send(10, 10, 0, -50, 4'b0100, 1, 1, 1, 50, 0, 0);
                idle(1);
            end
            begin
                int n;
                n = 0;
                while (!out_valid && n < 100) begin
                    @(negedge clk);
                    #1;
                    n++;
                end
                @(negedge clk);
                out_ready = 1'b0;
                repeat (5) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();

        // Protocol: first inside an open frame
        check("err_clear", ERR, 0);
        send(7, 7, 0, 0, 4'b0000, 1, 0, 0, 0, 0, 0);
        send(2, 3, 0, 0, 4'b0000, 1, 0, 0, 0, 0, 0);
        send(1, 1, 0, 0, 4'b0000, 0, 1, 1, 7, 0, 1);
        idle(5);
        drain();
        check("err_first_midframe", ERR, 1);

        // Protocol: beat in IDLE without first
        do_reset();
        #1;
        check("err_after_reset", ERR, 0);
        send(4, 4, 0, 0, 4'b0000, 0, 1, 0, 0, 0, 0);
        idle(8);
        check("err_orphan_beat", ERR, 1);
        check("orphan_no_out", out_valid, 0);

        // Overflow: positive, negative, then a clean frame clears OVF
        send(127, 127, 0, 0, 4'b0000, 1, 0, 0, 0, 0, 0);
        send(127, 127, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
        send(127, 127, 0, 0, 4'b0000, 0, 1, 1, EXP_POS_OVF, 1, 1);
        send(-128, 127, 0, 0, 4'b0000, 1, 0, 0, 0, 0, 0);
        send(-128, 127, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
        send(-128, 127, 0, 0, 4'b0000, 0, 1, 1, EXP_NEG_OVF, 1, 1);
        send(1, 1, 0, 0, 4'b0000, 1, 1, 1, 1, 0, 1);
        idle(2);
        drain();
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
